cdc_sync_bus: RTL and testbench



---
 rtl/cdc_sync_bus.sv | 92 +++++++++
 tb/tb_cdc_sync_bus.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cdc_sync_bus.sv
// rtl/cdc_sync_bus.sv - multi-channel level synchroniser with stability filter, edge pulses and glitch flags
module cdc_sync_bus #(
  parameter int                  CHANNELS  = 4,
  parameter int                  STAGES    = 2,
  parameter int                  FILTER    = 0,
  parameter logic [CHANNELS-1:0] RESET_VAL = '0
) (
  input  logic                CLK_i,
  input  logic                RST_N_i,
  input  logic [CHANNELS-1:0] ASYNC_i,
  input  logic                CLR_i,
  output logic [CHANNELS-1:0] SYNC_o,
  output logic [CHANNELS-1:0] RISE_o,
  output logic [CHANNELS-1:0] FALL_o,
  output logic [CHANNELS-1:0] GLITCH_o
);

  (* ASYNC_REG = "TRUE" *) logic [CHANNELS-1:0] chain [STAGES];

  // Plain flop chain per bit; stage 0 is the metastability catcher
  always_ff @(posedge CLK_i) begin
    if (!RST_N_i) begin
      for (int k = 0; k < STAGES; k++) chain[k] <= RESET_VAL;
    end else begin
      chain[0] <= ASYNC_i;
      for (int k = 1; k < STAGES; k++) chain[k] <= chain[k-1];
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic s;
    logic f_q;
    logic rise_q;
    logic fall_q;
    logic glitch_q;

    assign s = chain[STAGES-1][i];

    if (FILTER <= 1) begin : g_direct
      // No filtering: follow the synchronised level and pulse on every change
      always_ff @(posedge CLK_i) begin
        if (!RST_N_i) begin
          f_q      <= RESET_VAL[i];
          rise_q   <= 1'b0;
          fall_q   <= 1'b0;
          glitch_q <= 1'b0;
        end else begin
          f_q    <= s;
          rise_q <= (s != f_q) & s;
          fall_q <= (s != f_q) & ~s;
          if (CLR_i) glitch_q <= 1'b0;
        end
      end
    end else begin : g_filter
      localparam int CW = $clog2(FILTER + 1);
      logic [CW-1:0] cnt_q;

      // Accept a new level only after FILTER consecutive differing samples; flag abandoned runs
      always_ff @(posedge CLK_i) begin
        if (!RST_N_i) begin
          f_q      <= RESET_VAL[i];
          cnt_q    <= '0;
          rise_q   <= 1'b0;
          fall_q   <= 1'b0;
          glitch_q <= 1'b0;
        end else begin
          rise_q <= 1'b0;
          fall_q <= 1'b0;
          if (s == f_q) begin
            cnt_q <= '0;
          end else if (cnt_q == CW'(FILTER - 1)) begin
            f_q    <= s;
            cnt_q  <= '0;
            rise_q <= s;
            fall_q <= ~s;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
          // A new glitch outranks a simultaneous clear
          if ((s == f_q) && (cnt_q != '0)) glitch_q <= 1'b1;
          else if (CLR_i)                  glitch_q <= 1'b0;
        end
      end
    end

    assign SYNC_o[i]   = f_q;
    assign RISE_o[i]   = rise_q;
    assign FALL_o[i]   = fall_q;
    assign GLITCH_o[i] = glitch_q;
  end

endmodule

// File: tb/tb_cdc_sync_bus.sv
// tb/tb_cdc_sync_bus.sv - randomised model-based bench for cdc_sync_bus
module tb_cdc_sync_bus;

  localparam int MAXE = 4096;

  logic       clk;
  logic       rst_n;
  logic [7:0] async_in;
  logic       clr;
  logic [7:0] sync_a, rise_a, fall_a, gl_a;
  logic [7:0] sync_b, rise_b, fall_b, gl_b;

  int n_checks = 0;
  int n_pass   = 0;

  int         st_m [2] = '{2, 3};
  int         fl_m [2] = '{0, 4};
  logic [7:0] rv_m [2] = '{8'h00, 8'hA5};

  logic [7:0] hist [MAXE];
  bit         rsth [MAXE];
  int         en;
  bit         mvalid;
  logic [7:0] mf [2];
  logic [7:0] mr [2];
  logic [7:0] mfl [2];
  logic [7:0] mg [2];

  logic [7:0] cur, prv, sv, nf, nr, nfl, ng;
  int         fw, idx;
  bit         flip, gset;
  int         hold [8];

  cdc_sync_bus #(.CHANNELS(8), .STAGES(2), .FILTER(0), .RESET_VAL(8'h00)) dut_a (
    .CLK_i(clk), .RST_N_i(rst_n), .ASYNC_i(async_in), .CLR_i(clr),
    .SYNC_o(sync_a), .RISE_o(rise_a), .FALL_o(fall_a), .GLITCH_o(gl_a)
  );

  cdc_sync_bus #(.CHANNELS(8), .STAGES(3), .FILTER(4), .RESET_VAL(8'hA5)) dut_b (
    .CLK_i(clk), .RST_N_i(rst_n), .ASYNC_i(async_in), .CLR_i(clr),
    .SYNC_o(sync_b), .RISE_o(rise_b), .FALL_o(fall_b), .GLITCH_o(gl_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Synchronised level seen by the filter at edge n: input sampled STAGES edges earlier,
  // or the reset level if a reset edge lies within that span.
  function automatic logic [7:0] seen(input int m, input int n);
    if (n - st_m[m] < 0) return rv_m[m];
    for (int j = n - st_m[m]; j <= n - 1; j++) if (rsth[j]) return rv_m[m];
    return hist[n - st_m[m]];
  endfunction

  // Reference model: a level is accepted once the last max(FILTER,1) seen samples all differ from it
  initial begin
    en = -1;
    mvalid = 1'b0;
    forever begin
      @(posedge clk);
      if (en < MAXE - 1) en++;
      hist[en] = async_in;
      rsth[en] = !rst_n;
      for (int m = 0; m < 2; m++) begin
        if (!rst_n) begin
          mf[m] = rv_m[m]; mr[m] = '0; mfl[m] = '0; mg[m] = '0;
        end else begin
          fw  = (fl_m[m] < 1) ? 1 : fl_m[m];
          cur = seen(m, en);
          prv = seen(m, en - 1);
          for (int c = 0; c < 8; c++) begin
            flip = 1'b1;
            for (int k = 0; k < fw; k++) begin
              idx = en - k;
              if (idx < 0) flip = 1'b0;
              else if (rsth[idx]) flip = 1'b0;
              else begin
                sv = seen(m, idx);
                if (sv[c] == mf[m][c]) flip = 1'b0;
              end
            end
            nf[c]  = flip ? ~mf[m][c] : mf[m][c];
            nr[c]  = flip & ~mf[m][c];
            nfl[c] = flip & mf[m][c];
            gset = (fl_m[m] >= 2) && !flip && (cur[c] == mf[m][c]) && (en >= 1)
                   && !rsth[en-1] && (prv[c] != mf[m][c]);
            ng[c] = gset ? 1'b1 : (clr ? 1'b0 : mg[m][c]);
          end
          mf[m] = nf; mr[m] = nr; mfl[m] = nfl; mg[m] = ng;
        end
      end
      mvalid = 1'b1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (mvalid) begin
        check("sync_a", sync_a, mf[0]);
        check("rise_a", rise_a, mr[0]);
        check("fall_a", fall_a, mfl[0]);
        check("glitch_a", gl_a, mg[0]);
        check("sync_b", sync_b, mf[1]);
        check("rise_b", rise_b, mr[1]);
        check("fall_b", fall_b, mfl[1]);
        check("glitch_b", gl_b, mg[1]);
        check("rise_and_fall_a", rise_a & fall_a, 8'h00);
        check("rise_and_fall_b", rise_b & fall_b, 8'h00);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    async_in = 8'hFF;
    clr      = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_sync_a", sync_a, 8'h00);
    check("rst_rise_a", rise_a, 8'h00);
    check("rst_sync_b", sync_b, 8'hA5);
    check("rst_glitch_b", gl_b, 8'h00);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      case (e)
        2: begin check("lat_sync_a_e2", sync_a, 8'h00); check("lat_rise_a_e2", rise_a, 8'h00); end
        3: begin
          check("lat_sync_a_e3", sync_a, 8'hFF);
          check("lat_rise_a_e3", rise_a, 8'hFF);
          check("model_sync_a_e3", mf[0], 8'hFF);
        end
        4: check("lat_rise_a_e4", rise_a, 8'h00);
        6: check("lat_sync_b_e6", sync_b, 8'hA5);
        7: begin
          check("lat_sync_b_e7", sync_b, 8'hFF);
          check("lat_rise_b_e7", rise_b, 8'h5A);
          check("lat_fall_b_e7", fall_b, 8'h00);
          check("model_rise_b_e7", mr[1], 8'h5A);
        end
        8: check("lat_rise_b_e8", rise_b, 8'h00);
        default: ;
      endcase
    end

    async_in = 8'hFD;
    repeat (3) @(negedge clk);
    async_in = 8'hFF;
    repeat (3) @(negedge clk);
    check("glitch_b_before", gl_b, 8'h00);
    clr = 1'b1;
    @(negedge clk);
    check("glitch_b_set_wins", gl_b, 8'h02);
    check("glitch_sync_b_held", sync_b, 8'hFF);
    check("model_glitch_b", mg[1], 8'h02);
    check("glitch_a_never", gl_a, 8'h00);
    @(negedge clk);
    check("glitch_b_cleared", gl_b, 8'h00);
    clr = 1'b0;

    for (int c = 0; c < 8; c++) hold[c] = $urandom_range(1, 10);
    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < 8; c++) begin
        if (hold[c] <= 1) begin
          async_in[c] = ~async_in[c];
          hold[c] = $urandom_range(1, 10);
        end else begin
          hold[c] = hold[c] - 1;
        end
      end
      clr   = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
    end
    rst_n = 1'b1;
    clr   = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
